// File: rtl/player_crash_monitor.sv
// Player crash monitor: once per video frame, snapshots the player and AI car
// boxes and scans the cars one per cycle for a bounding-box overlap with the
// player. A hit raises a one-cycle crash_pulse and holds the player in a
// recovery window of RECOVER_FRAMES frames.
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset          asynchronous active-high reset
//   frame_start    one-cycle pulse at the start of each video frame
//   player_state   player {img_id, x, y, width, height}, 11 bits each
//   ai_car_states  per-car {img_id, x, y, width, height}
//   crash_pulse    one-cycle pulse on a detected collision
//   crashed        high while recovering
//   speed_hold     request to force player speed to 0 (equals crashed)
//   hit_car_index  index of the last colliding car, held until next crash
//   scan_done      one-cycle pulse when a scan finishes with no hit
//   crash_count    (only with CRASH_COUNT_EN) saturating 8-bit crash count
//
// Optional feature macro: CRASH_COUNT_EN adds the crash_count output.

module player_crash_monitor #(
    parameter int NUM_CARS       = 4,
    parameter int RECOVER_FRAMES = 60
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_start,
    input  logic [0:4][0:10]                 player_state,
    input  logic [0:NUM_CARS-1][0:4][0:10]   ai_car_states,
    output logic                             crash_pulse,
    output logic                             crashed,
    output logic                             speed_hold,
    output logic [2:0]                       hit_car_index,
    output logic                             scan_done
`ifdef CRASH_COUNT_EN
    ,
    output logic [7:0]                       crash_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CRASH,
        RECOVER
    } state_t;

    state_t state_q, state_d;

    logic [2:0] idx_q, idx_d;
    logic [2:0] hit_q, hit_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       snap_en;

    // Player img_id is not used for collision; only its geometry is kept.
    logic [1:4][0:10]               ply_q;
    logic [0:NUM_CARS-1][0:4][0:10] car_q;

    logic                           unused_ply_img;
    assign unused_ply_img = ^player_state[0];

    // ---------------------------------------------------------------
    // Car selected by the scan index
    // ---------------------------------------------------------------
    logic [0:4][0:10] cur;

    always_comb begin
        cur = '0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (idx_q == 3'(k)) begin
                cur = car_q[k];
            end
        end
    end

    // ---------------------------------------------------------------
    // Overlap test; 12-bit sums so x+w can never wrap
    // ---------------------------------------------------------------
    logic [11:0] px, py, pw, ph;
    logic [11:0] cx, cy, cw, ch;
    logic        cur_active;
    logic        overlap;
    logic        last_car;

    assign px = {1'b0, ply_q[1]};
    assign py = {1'b0, ply_q[2]};
    assign pw = {1'b0, ply_q[3]};
    assign ph = {1'b0, ply_q[4]};
    assign cx = {1'b0, cur[1]};
    assign cy = {1'b0, cur[2]};
    assign cw = {1'b0, cur[3]};
    assign ch = {1'b0, cur[4]};

    assign cur_active = (cur[0] != 11'd0);

    assign overlap = cur_active
                   && (px < cx + cw)
                   && (cx < px + pw)
                   && (py < cy + ch)
                   && (cy < py + ph);

    assign last_car = (idx_q == 3'(NUM_CARS - 1));

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state and datapath control
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        snap_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SCAN;
                    idx_d   = 3'd0;
                    snap_en = 1'b1;
                end
            end
            SCAN: begin
                // A new frame wins over the compare in flight.
                if (frame_start) begin
                    idx_d   = 3'd0;
                    snap_en = 1'b1;
                end else if (overlap) begin
                    state_d = CRASH;
                    hit_d   = idx_q;
                end else if (last_car) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            CRASH: begin
                state_d = RECOVER;
                cnt_d   = 8'(RECOVER_FRAMES);
            end
            RECOVER: begin
                if (frame_start) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= 3'd0;
            hit_q  <= 3'd0;
            cnt_q  <= 8'd0;
            done_q <= 1'b0;
            ply_q  <= '0;
            car_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            hit_q  <= hit_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            if (snap_en) begin
                ply_q <= player_state[1:4];
                car_q <= ai_car_states;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        crash_pulse   = (state_q == CRASH);
        crashed       = (state_q == RECOVER);
        speed_hold    = (state_q == RECOVER);
        hit_car_index = hit_q;
        scan_done     = done_q;
    end

`ifdef CRASH_COUNT_EN
    logic [7:0] ccnt_q, ccnt_d;

    always_comb begin
        ccnt_d = ccnt_q;
        if (state_q == CRASH && ccnt_q != 8'hFF) begin
            ccnt_d = ccnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ccnt_q <= 8'd0;
        end else begin
            ccnt_q <= ccnt_d;
        end
    end

    assign crash_count = ccnt_q;
`endif

endmodule

// File: tb/tb_player_crash_monitor.sv
// Scoreboard bench for player_crash_monitor: each frame pushes the predicted
// event (crash with index, or scan_done) and its cycle; a monitor pops on output.

module tb_player_crash_monitor;

    localparam int NC = 4;
    localparam int RF = 3;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     frame_start = 1'b0;
    logic [0:4][0:10]         ply = '0;
    logic [0:NC-1][0:4][0:10] cars = '0;
    logic                     crash_pulse;
    logic                     crashed;
    logic                     speed_hold;
    logic [2:0]               hit_car_index;
    logic                     scan_done;
`ifdef CRASH_COUNT_EN
    logic [7:0]               crash_count;
`endif

    player_crash_monitor #(
        .NUM_CARS      (NC),
        .RECOVER_FRAMES(RF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .player_state (ply),
        .ai_car_states(cars),
        .crash_pulse  (crash_pulse),
        .crashed      (crashed),
        .speed_hold   (speed_hold),
        .hit_car_index(hit_car_index),
        .scan_done    (scan_done)
`ifdef CRASH_COUNT_EN
        ,
        .crash_count  (crash_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        int kind;   // 1 = crash, 0 = scan_done
        int idx;
        int cyc;
    } ev_t;

    ev_t exq[$];
    int  rec_left = 0;

    // Monitor: every output event must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && (crash_pulse || scan_done)) begin
            if (exq.size() == 0) begin
                chk("unexpected_event",
                    int'(crash_pulse) * 2 + int'(scan_done), 0);
            end else begin
                ev_t e;
                e = exq.pop_front();
                chk("event_kind", int'(crash_pulse), e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (e.kind == 1)
                    chk("hit_idx", int'(hit_car_index), e.idx);
            end
        end
    end

    function automatic bit ov(input int k);
        int px, py, pw, ph, cx, cy, cw, ch;
        px = int'(ply[1]);     py = int'(ply[2]);
        pw = int'(ply[3]);     ph = int'(ply[4]);
        cx = int'(cars[k][1]); cy = int'(cars[k][2]);
        cw = int'(cars[k][3]); ch = int'(cars[k][4]);
        return !(px >= cx + cw || cx >= px + pw ||
                 py >= cy + ch || cy >= py + ph);
    endfunction

    function automatic int model_hit();
        for (int k = 0; k < NC; k++)
            if (cars[k][0] != 11'd0 && ov(k))
                return k;
        return -1;
    endfunction

    task automatic set_ply(input int img, x, y, w, h);
        ply = {11'(img), 11'(x), 11'(y), 11'(w), 11'(h)};
    endtask

    task automatic set_car(input int k, input int img, x, y, w, h);
        cars[k] = {11'(img), 11'(x), 11'(y), 11'(w), 11'(h)};
    endtask

    // Pulse frame_start; when pred is set, push the model's expectation.
    task automatic frame(input bit pred);
        int e0, h;
        ev_t e;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        e0 = cyc;
        if (pred) begin
            if (rec_left > 0) begin
                rec_left--;
            end else begin
                h = model_hit();
                if (h >= 0) begin
                    e = '{kind: 1, idx: h, cyc: e0 + h + 1};
                    rec_left = RF;
                end else begin
                    e = '{kind: 0, idx: 0, cyc: e0 + NC};
                end
                exq.push_back(e);
            end
        end
    endtask

    task automatic frame_wait();
        frame(1'b1);
        repeat (NC + 2) @(negedge clk);
        chk("pending_events", exq.size(), 0);
    endtask

    task automatic recover();
        while (rec_left > 0) frame_wait();
        chk("crashed_after_recover", int'(crashed), 0);
    endtask

    task automatic clear_cars();
        cars = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_crash_pulse", int'(crash_pulse), 0);
        chk("rst_crashed", int'(crashed), 0);
        chk("rst_speed_hold", int'(speed_hold), 0);
        chk("rst_hit_idx", int'(hit_car_index), 0);
        chk("rst_scan_done", int'(scan_done), 0);
`ifdef CRASH_COUNT_EN
        chk("rst_crash_count", int'(crash_count), 0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Head-on overlap with car 0, then recovery with car still overlapping
        set_ply(1, 160, 380, 64, 64);
        clear_cars();
        set_car(0, 1, 160, 350, 64, 64);
        frame_wait();
        chk("crashed_high", int'(crashed), 1);
        chk("speed_hold_high", int'(speed_hold), 1);
        frame_wait();
        frame_wait();
        chk("crashed_after_2_frames", int'(crashed), 1);
        frame(1'b1);
        chk("crashed_falls_3rd", int'(crashed), 0);
        repeat (NC + 2) @(negedge clk);
        chk("pending_recover", exq.size(), 0);

        // Touching edge: no crash, scan_done
        clear_cars();
        set_car(1, 1, 224, 380, 64, 64);
        frame_wait();

        // Cars 1 and 3 overlap: lowest wins
        clear_cars();
        set_car(1, 2, 150, 390, 30, 30);
        set_car(3, 3, 170, 400, 30, 30);
        frame_wait();
        chk("hit_idx_held", int'(hit_car_index), 1);
        recover();

        // Inactive car exactly on the player
        clear_cars();
        set_car(0, 0, 160, 380, 64, 64);
        frame_wait();

        // Sums must not wrap at 11 bits
        set_ply(1, 1500, 100, 10, 50);
        clear_cars();
        set_car(0, 1, 1000, 100, 1100, 50);
        frame_wait();
        recover();

        // Reset 2 cycles into a scan that would hit car 3
        set_ply(1, 160, 380, 64, 64);
        clear_cars();
        set_car(3, 1, 170, 390, 20, 20);
        frame(1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midscan_rst_pulse", int'(crash_pulse), 0);
        chk("midscan_rst_done", int'(scan_done), 0);
        chk("midscan_rst_hit", int'(hit_car_index), 0);
        reset = 1'b0;
        repeat (NC + 2) @(negedge clk);
        chk("pending_after_rst", exq.size(), 0);
        frame_wait();
        recover();

        // Restart: second frame_start mid-scan uses new snapshot
        clear_cars();
        set_car(0, 1, 1200, 1200, 10, 10);
        frame(1'b0);
        set_car(2, 1, 180, 400, 10, 10);
        frame(1'b1);
        repeat (NC + 2) @(negedge clk);
        chk("pending_restart", exq.size(), 0);
        recover();

        // Random frames
        for (int i = 0; i < 24; i++) begin
            set_ply(1, $urandom_range(400), $urandom_range(400),
                    $urandom_range(150, 1), $urandom_range(150, 1));
            for (int k = 0; k < NC; k++)
                set_car(k, $urandom_range(2), $urandom_range(400),
                        $urandom_range(400), $urandom_range(150, 1),
                        $urandom_range(150, 1));
            frame_wait();
            recover();
        end

`ifdef CRASH_COUNT_EN
        set_ply(1, 160, 380, 64, 64);
        clear_cars();
        set_car(0, 1, 160, 350, 64, 64);
        for (int i = 0; i < 300; i++) begin
            frame_wait();
            recover();
        end
        chk("crash_count_sat", int'(crash_count), 255);
`endif

        chk("final_pending", exq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
